// File: rtl/sig_control.sv
// Highway/country-road traffic signal controller: Moore FSM with 8-bit dwell counter.
// Define SIG_CONTROL_MIN_GREEN_EN to enforce a minimum highway-green time of MIN_GREEN cycles.
module sig_control #(
  parameter int unsigned Y2R_DELAY = 3,
  parameter int unsigned R2G_DELAY = 2,
  parameter int unsigned MIN_GREEN = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] hwy,
  output logic [1:0] cntry
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4
  } state_e;

  localparam logic [1:0] Red    = 2'd0;
  localparam logic [1:0] Yellow = 2'd1;
  localparam logic [1:0] Green  = 2'd2;

  localparam logic [7:0] Y2rLast   = 8'(Y2R_DELAY - 1);
  localparam logic [7:0] R2gLast   = 8'(R2G_DELAY - 1);
  localparam logic [7:0] MinGreen  = 8'(MIN_GREEN);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] hwy_q, hwy_d;
  logic [1:0] cntry_q, cntry_d;
  logic       green_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = 8'd0;
    case (state_q)
      S0: if (X && green_ok) state_d = S1;
      S1: begin
        if (cnt_q == Y2rLast) state_d = S2;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      S2: begin
        if (cnt_q == R2gLast) state_d = S3;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      S3: if (!X) state_d = S4;
      S4: begin
        if (cnt_q == Y2rLast) state_d = S0;
        else                  cnt_d   = cnt_q + 8'd1;
      end
      default: state_d = S0;
    endcase
  end

  // Lamps are decoded from the next state so the registered outputs track the state register.
  always_comb begin
    hwy_d   = Red;
    cntry_d = Red;
    case (state_d)
      S0:      hwy_d   = Green;
      S1:      hwy_d   = Yellow;
      S3:      cntry_d = Green;
      S4:      cntry_d = Yellow;
      default: begin
        hwy_d   = Red;
        cntry_d = Red;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= S0;
      cnt_q   <= 8'd0;
      hwy_q   <= Green;
      cntry_q <= Red;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hwy_q   <= hwy_d;
      cntry_q <= cntry_d;
    end
  end

`ifdef SIG_CONTROL_MIN_GREEN_EN
  logic [7:0] age_q, age_d;

  // age_q counts completed green cycles before this one, so the current cycle makes age_q + 1.
  assign green_ok = ({1'b0, age_q} + 9'd1) >= {1'b0, MinGreen};

  always_comb begin
    age_d = 8'd0;
    if (state_q == S0 && state_d == S0) begin
      age_d = (age_q < MinGreen) ? age_q + 8'd1 : age_q;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) age_q <= 8'd0;
    else       age_q <= age_d;
  end
`else
  logic unused_min_green;
  assign unused_min_green = ^MinGreen;
  assign green_ok         = 1'b1;
`endif

  assign hwy   = hwy_q;
  assign cntry = cntry_q;

endmodule

// File: tb/tb_sig_control.sv
// Scoreboard bench for sig_control: a plan-queue reference model pushes expected lamps per edge,
// a negedge monitor pops and compares. Honours SIG_CONTROL_MIN_GREEN_EN.
module tb_sig_control;

  localparam int Y2R = 3;
  localparam int R2G = 2;
`ifdef SIG_CONTROL_MIN_GREEN_EN
  localparam int MinG = 4;
`else
  localparam int MinG = 1;
`endif

  // Lamp pairs packed as {hwy, cntry}.
  localparam logic [3:0] HG = 4'b1000;
  localparam logic [3:0] YR = 4'b0100;
  localparam logic [3:0] RR = 4'b0000;
  localparam logic [3:0] CG = 4'b0010;
  localparam logic [3:0] CY = 4'b0001;

  logic       clock = 1'b0;
  logic       clear;
  logic       x;
  logic [1:0] hwy, cntry;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] exp_q[$];

  // Reference model state: pending forced lamp sequence plus the resting direction.
  logic [3:0] plan[$];
  logic [3:0] cur = HG;
  bit         cntry_mode = 1'b0;
  int         green_cycles = 1;

  sig_control #(
    .Y2R_DELAY(Y2R),
    .R2G_DELAY(R2G),
    .MIN_GREEN(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .X    (x),
    .hwy  (hwy),
    .cntry(cntry)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got hwy/cntry=%b/%b, expected %b/%b",
               name, $time, act[3:2], act[1:0], exp[3:2], exp[1:0]);
    end
  endtask

  // Reference model: evaluated at each rising edge, or reset asynchronously.
  initial forever begin
    logic [3:0] idle, nxt;
    @(posedge clock or posedge clear);
    if (clear) begin
      plan.delete();
      exp_q.delete();
      cur          = HG;
      cntry_mode   = 1'b0;
      green_cycles = 1;
    end else begin
      idle = cntry_mode ? CG : HG;
      if (plan.size() > 0) begin
        nxt = plan.pop_front();
      end else if (cur != idle) begin
        nxt = idle;
      end else if (!cntry_mode && x && green_cycles >= MinG) begin
        repeat (Y2R) plan.push_back(YR);
        repeat (R2G) plan.push_back(RR);
        cntry_mode = 1'b1;
        nxt        = plan.pop_front();
      end else if (cntry_mode && !x) begin
        repeat (Y2R) plan.push_back(CY);
        cntry_mode = 1'b0;
        nxt        = plan.pop_front();
      end else begin
        nxt = idle;
      end
      if (nxt == HG) green_cycles = (cur == HG) ? green_cycles + 1 : 1;
      cur = nxt;
      exp_q.push_back(nxt);
    end
  end

  // Monitor: compare the DUT lamps against the scoreboard away from the active edge.
  initial forever begin
    logic [3:0] e;
    @(negedge clock);
    if (clear) begin
      check("reset_hold", {hwy, cntry}, HG);
    end else if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL underflow at %0t: got hwy/cntry=%b/%b, expected a queued entry",
               $time, hwy, cntry);
    end else begin
      e = exp_q.pop_front();
      check("lamp", {hwy, cntry}, e);
    end
    n_cmp++;
    if (hwy == 2'd3 || cntry == 2'd3 || (hwy != 2'd0 && cntry != 2'd0)) begin
      n_bad++;
      $display("FAIL invariant at %0t: got hwy/cntry=%b/%b, expected legal and one side red",
               $time, hwy, cntry);
    end
  end

  task automatic run(input bit v, input int n);
    repeat (n) begin
      @(negedge clock);
      #2;
      x = v;
    end
  endtask

  initial begin
    int len;
    clear = 1'b1;
    x     = 1'b0;
    run(0, 5);
    @(negedge clock);
    #2;
    clear = 1'b0;

    // Directed request, hold, ignore-during-timed and repeated requests.
    run(0, 19);
    run(1, 10);
    run(0, 15);
    run(1, 50);
    run(0, 20);
    run(1, 1);
    run(0, 20);
    for (int i = 0; i < 3; i++) begin
      run(1, 8);
      run(0, (i == 1) ? 10 : 20);
    end

    // Random segments.
    for (int i = 0; i < 40; i++) begin
      len = int'($urandom_range(1, 15));
      run(1'($urandom_range(0, 1)), len);
    end

    // Asynchronous clear in the middle of country green.
    run(0, 30);
    run(1, Y2R + R2G + 4);
    @(negedge clock);
    #2;
    clear = 1'b1;
    #1;
    check("async_clear", {hwy, cntry}, HG);
    run(1, 2);
    @(negedge clock);
    #2;
    clear = 1'b0;
    x     = 1'b0;
    run(0, 10);
    run(1, 12);
    run(0, 12);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sig_control.md
Name: sig_control

Overview:
Highway/country-road traffic signal controller. Moore FSM with internal dwell counters. The highway holds green by default. A car sensed on the country road makes the highway go yellow, then all-red, then country green. Country green holds while cars remain, then country yellow, then highway green again. Sits between the road-sensor input and the lamp drivers.

Parameters:
- Y2R_DELAY, 3, clock cycles spent in each yellow state (S1, S4); legal range 1..255.
- R2G_DELAY, 2, clock cycles spent in the all-red state S2; legal range 1..255.
- MIN_GREEN, 4, minimum highway-green cycles; used only with the optional feature; legal range 1..255.

Ports:
- clock  input  1  rising-edge system clock.
- clear  input  1  asynchronous active-high reset.
- X  input  1  car present on country road; sampled on clock rising edge.
- hwy  output  2  highway lamp code: RED=2'd0, YELLOW=2'd1, GREEN=2'd2.
- cntry  output  2  country lamp code, same encoding.

Behaviour:
- Interface: one clock (clock); reset (clear) is asynchronous and active-high.
- Encoding: 2'd3 is never driven on hwy or cntry.
- States and outputs (Moore; outputs decoded from the state register only, no combinational path from X):
  - S0: hwy=GREEN, cntry=RED.
  - S1: hwy=YELLOW, cntry=RED.
  - S2: hwy=RED, cntry=RED.
  - S3: hwy=RED, cntry=GREEN.
  - S4: hwy=RED, cntry=YELLOW.
- Reset: while clear=1, and immediately on its assertion regardless of clock: state=S0, dwell counter=0, hwy=GREEN, cntry=RED. X is ignored during reset.
- Dwell counter:
  - Loaded to 0 on every state change.
  - In a timed state (S1, S2, S4): if count==DELAY-1, transition and clear the counter; otherwise increment.
  - Each timed state therefore lasts exactly DELAY cycles.
- Transitions, evaluated at each rising edge:
  - S0: X=1 -> S1; else stay.
  - S1: after Y2R_DELAY cycles -> S2.
  - S2: after R2G_DELAY cycles -> S3.
  - S3: X=0 -> S4; else stay. No maximum green time.
  - S4: after Y2R_DELAY cycles -> S0.
- Latency: X=1 sampled at edge t in S0 gives hwy=YELLOW after edge t. Country green starts after edge t+Y2R_DELAY+R2G_DELAY.
- X is ignored in S1, S2 and S4; a sequence in progress always completes.
- X toggling in S0/S3 takes effect at the very next edge; single-cycle pulses are honoured.
- Illegal/unused state encodings go to S0 on the next edge, counter cleared.
- Both directions are never non-RED simultaneously in any state.
- Counter width: 8 bits.

Optional Feature:
- Macro: SIG_CONTROL_MIN_GREEN_EN.
- With macro defined:
  - S0 keeps a green-age counter, cleared on entry to S0 and on reset, saturating at MIN_GREEN.
  - S0->S1 occurs only when X=1 and the counter has reached MIN_GREEN, i.e. highway green lasts at least MIN_GREEN cycles.
  - X=1 earlier is not latched; it must still be 1 when the minimum expires.
  - A request arriving during reset release is therefore delayed to cycle MIN_GREEN.
- Without macro: no green-age counter; S0 honours X immediately; MIN_GREEN is unused.

Test Plan:
- Reset: clear=1 for 5 cycles with X=0, then release -> hwy=2'b10, cntry=2'b00 throughout; clear asserted mid-S3 -> outputs return to 10/00 asynchronously, without waiting for a clock edge.
- Request cycle: defaults, X=1 at cycle 20 after reset, held 10 cycles -> hwy=01 for 3 cycles; then 00/00 for 2 cycles; then cntry=10 until X falls; then cntry=01 for 3 cycles; then hwy=10.
- Hold: X held high 50 cycles -> cntry stays GREEN indefinitely, no timeout; X=0 -> S4 on the next edge.
- Ignore during timed states: X drops to 0 during S1 -> sequence still reaches S3, then exits to S4 on the following edge because X=0.
- Repeat: three requests spaced 20/10 cycles apart -> identical cycle-exact lamp sequences each time; no 2'b11 ever seen; never both outputs non-RED.
- Min green (SIG_CONTROL_MIN_GREEN_EN, MIN_GREEN=4): X=1 from the first cycle after reset -> hwy stays GREEN 4 cycles before YELLOW. Without the macro -> YELLOW after 1 edge.
